// File: rtl/dvv_hw_pkg.sv
// Shared constants and types for the dvv hardware socket path.
package dvv_hw_pkg;

  localparam int unsigned DVV_DW    = 32;
  localparam int unsigned DVV_DEPTH = 8;

  typedef logic [DVV_DW-1:0] dvv_word_t;

  typedef struct packed {
    logic ovf;
    logic udf;
  } dvv_fifo_err_t;

endpackage

// File: rtl/dvv_sock_fifo_mem.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous read port.
module dvv_sock_fifo_mem #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  // Storage is intentionally not reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dvv_sock_fifo.sv
// FWFT transaction buffer between the dvv socket producer and the DUT pin driver.
// Optional statistics outputs are enabled by defining DVV_SOCK_FIFO_STAT_EN.
module dvv_sock_fifo
  import dvv_hw_pkg::*;
#(
  parameter int unsigned DW    = DVV_DW,
  parameter int unsigned DEPTH = DVV_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW:0]   count,
  output logic          ovf_err,
  output logic          udf_err
`ifdef DVV_SOCK_FIFO_STAT_EN
  ,
  output logic [31:0]   stat_push,
  output logic [31:0]   stat_pop,
  output logic [AW:0]   stat_max
`endif
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  dvv_fifo_err_t err_q, err_d;
  logic          full, empty, push, pop;

`ifdef DVV_SOCK_FIFO_STAT_EN
  logic [31:0]   stat_push_q, stat_push_d;
  logic [31:0]   stat_pop_q, stat_pop_d;
  logic [AW:0]   stat_max_q, stat_max_d;
`endif

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = wr_valid & ~full;
  assign pop   = rd_ready & ~empty;

  assign wr_ready = ~full;
  assign rd_valid = ~empty;
  assign count    = wr_ptr_q - rd_ptr_q;
  assign ovf_err  = err_q.ovf;
  assign udf_err  = err_q.udf;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q;
`ifdef DVV_SOCK_FIFO_STAT_EN
    stat_push_d = stat_push_q;
    stat_pop_d  = stat_pop_q;
    stat_max_d  = (count > stat_max_q) ? count : stat_max_q;
`endif
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      err_d    = '0;
`ifdef DVV_SOCK_FIFO_STAT_EN
      stat_push_d = '0;
      stat_pop_d  = '0;
      stat_max_d  = '0;
`endif
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      err_d.ovf = err_q.ovf | (wr_valid & full);
      err_d.udf = err_q.udf | (rd_ready & empty);
`ifdef DVV_SOCK_FIFO_STAT_EN
      if (push) stat_push_d = stat_push_q + 32'd1;
      if (pop)  stat_pop_d  = stat_pop_q + 32'd1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= '0;
`ifdef DVV_SOCK_FIFO_STAT_EN
      stat_push_q <= '0;
      stat_pop_q  <= '0;
      stat_max_q  <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
`ifdef DVV_SOCK_FIFO_STAT_EN
      stat_push_q <= stat_push_d;
      stat_pop_q  <= stat_pop_d;
      stat_max_q  <= stat_max_d;
`endif
    end
  end

`ifdef DVV_SOCK_FIFO_STAT_EN
  assign stat_push = stat_push_q;
  assign stat_pop  = stat_pop_q;
  assign stat_max  = stat_max_q;
`endif

  dvv_sock_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_data)
  );

endmodule
